// File: rtl/care_scheduler.sv
// care_scheduler
//
// Sequences care actions into the pet statistics datapath. Button presses from six
// requesters are latched as pending work. Pending work is granted one action at a time,
// round-robin, as a single-cycle one-hot pulse. A fixed cooldown follows each grant.
// The block also produces the periodic decay tick. While fatigue is high it runs an
// autonomous sleep mode that issues a rest pulse after every tick.
//
// Ports:
//   clk       system clock, posedge
//   reset     asynchronous active-high reset
//   req       level requests: 0 feed, 1 play, 2 heal, 3 clean, 4 rest, 5 socialize
//   energy    fatigue stat from the stats block
//   action    registered one-hot pulse to the stats inputs bus (bits 7:6 always 0)
//   grant_id  index of the last granted action
//   tick      registered one-cycle decay strobe
//   busy      FSM not idle
//   asleep    FSM in sleep mode
module care_scheduler #(
    parameter int unsigned TICK_PERIOD = 1000,
    parameter int unsigned COOLDOWN    = 15,
    parameter int unsigned SLEEP_LEVEL = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] req,
    input  logic [3:0] energy,
    output logic [7:0] action,
    output logic [2:0] grant_id,
    output logic       tick,
    output logic       busy,
    output logic       asleep
);

    localparam int unsigned TW = $clog2(TICK_PERIOD);
    localparam int unsigned CW = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {StIdle, StGrant, StCool, StSleep} state_e;

    state_e          state_q, state_d;
    logic [5:0]      req_q, req_d;
    logic [5:0]      pending_q, pending_d;
    logic [2:0]      last_grant_q, last_grant_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic [7:0]      action_q, action_d;
    logic            tick_q, tick_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]   cool_q, cool_d;

    logic [5:0]      req_edge;
    logic [2:0]      winner;
    logic            found;
    logic [3:0]      rr_sum;
    logic [2:0]      rr_idx;

    assign req_edge = req & ~req_q;

    // Round-robin search starting one past the last granted action, wrapping at 6.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        rr_sum = 4'd0;
        rr_idx = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            rr_sum = {1'b0, last_grant_q} + 4'(k);
            if (rr_sum >= 4'd6) begin
                rr_sum = rr_sum - 4'd6;
            end
            rr_idx = rr_sum[2:0];
            if (!found && pending_q[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end

    always_comb begin
        req_d        = req;
        state_d      = state_q;
        action_d     = 8'h00;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cool_d       = cool_q;
        pending_d    = pending_q | req_edge;

        // Free-running decay tick, independent of the FSM.
        tick_d = (tick_cnt_q == TW'(TICK_PERIOD - 1));
        if (tick_d) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // Sleep takes priority over pending work.
                if (energy >= 4'(SLEEP_LEVEL)) begin
                    state_d = StSleep;
                end else if (|pending_q) begin
                    state_d    = StGrant;
                    grant_id_d = winner;
                    action_d   = 8'h01 << winner;
                end
            end
            StGrant: begin
                // A new edge on the granted bit in this cycle re-arms it.
                pending_d    = (pending_q & ~(6'h01 << grant_id_q)) | req_edge;
                last_grant_d = grant_id_q;
                cool_d       = CW'(COOLDOWN - 1);
                state_d      = StCool;
            end
            StCool: begin
                if (cool_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end
            StSleep: begin
                if (tick_q) begin
                    action_d = 8'h10;
                end
                // Leave only once no rest pulse is owed or in flight.
                if (energy == 4'd0 && !tick_q && !action_q[4]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            req_q        <= 6'h00;
            pending_q    <= 6'h00;
            last_grant_q <= 3'd5;
            grant_id_q   <= 3'd0;
            action_q     <= 8'h00;
            tick_q       <= 1'b0;
            tick_cnt_q   <= '0;
            cool_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            action_q     <= action_d;
            tick_q       <= tick_d;
            tick_cnt_q   <= tick_cnt_d;
            cool_q       <= cool_d;
        end
    end

    assign action   = action_q;
    assign grant_id = grant_id_q;
    assign tick     = tick_q;
    assign busy     = (state_q != StIdle);
    assign asleep   = (state_q == StSleep);

endmodule

// File: tb/tb_care_scheduler.sv
module tb_care_scheduler;

    logic       clk;
    logic       reset;
    logic [5:0] req;
    logic [3:0] energy;
    logic [7:0] action;
    logic [2:0] grant_id;
    logic       tick;
    logic       busy;
    logic       asleep;
    logic [7:0] action2;
    logic [2:0] grant_id2;
    logic       tick2;
    logic       busy2;
    logic       asleep2;

    care_scheduler #(
        .TICK_PERIOD(64),
        .COOLDOWN   (15),
        .SLEEP_LEVEL(12)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .energy  (energy),
        .action  (action),
        .grant_id(grant_id),
        .tick    (tick),
        .busy    (busy),
        .asleep  (asleep)
    );

    // Short-period copy used only to observe tick spacing.
    care_scheduler #(
        .TICK_PERIOD(4),
        .COOLDOWN   (15),
        .SLEEP_LEVEL(12)
    ) u_dut_tick (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .energy  (energy),
        .action  (action2),
        .grant_id(grant_id2),
        .tick    (tick2),
        .busy    (busy2),
        .asleep  (asleep2)
    );

    typedef struct {
        logic [7:0] act;
        logic [2:0] gid;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: edge k after reset release makes cyc == k.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] a, input logic [2:0] g, input int c);
        exp_t e;
        e.act = a;
        e.gid = g;
        e.cyc = c;
        q.push_back(e);
    endtask

    // Every action pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && action !== 8'h00) begin
            if (q.size() == 0) begin
                chk("unexpected_action", {24'h0, action}, 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("action", {24'h0, action}, {24'h0, e.act});
                chk("grant_id", {29'h0, grant_id}, {29'h0, e.gid});
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int busy_cnt;
        int n;
        int t;
        reset  = 1'b1;
        req    = 6'h00;
        energy = 4'd0;
        step(2);
        chk("rst_action", {24'h0, action}, 32'h0);
        chk("rst_grant_id", {29'h0, grant_id}, 32'h0);
        chk("rst_tick", {31'h0, tick}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_asleep", {31'h0, asleep}, 32'h0);

        // Single request together with tick spacing on the short-period copy.
        reset = 1'b0;
        req   = 6'h01;
        push(8'h01, 3'd0, 2);
        busy_cnt = 0;
        for (int c = 1; c <= 25; c++) begin
            step(1);
            if (c == 1) req = 6'h00;
            if (busy) busy_cnt++;
            if (c <= 13) chk($sformatf("tick_c%0d", c), {31'h0, tick2}, {31'h0, (c % 4 == 0)});
        end
        chk("busy_len", busy_cnt, 16);

        // Asynchronous reset while in the grant cycle.
        n   = cyc;
        req = 6'h08;
        push(8'h08, 3'd3, n + 2);
        step(2);
        #1;
        reset = 1'b1;
        req   = 6'h00;
        #1;
        chk("async_action", {24'h0, action}, 32'h0);
        chk("async_busy", {31'h0, busy}, 32'h0);
        chk("async_grant_id", {29'h0, grant_id}, 32'h0);
        chk("async_asleep", {31'h0, asleep}, 32'h0);
        step(1);
        reset = 1'b0;
        step(40);

        // Round-robin over all six requesters raised on the same edge.
        n   = cyc;
        req = 6'h3F;
        for (int i = 0; i < 6; i++) push(8'h01 << i, 3'(i), n + 2 + 17 * i);
        step(6 * 17 + 30);
        req = 6'h00;
        step(5);

        // Wrap: last grant 4, pending {1,5} -> 5 then 1.
        n   = cyc;
        req = 6'h10;
        push(8'h10, 3'd4, n + 2);
        step(4);
        req = 6'h22;
        push(8'h20, 3'd5, n + 19);
        push(8'h02, 3'd1, n + 36);
        step(50);
        req = 6'h00;
        step(2);

        // Sleep with heal pending: only rest pulses until energy drops to zero.
        energy = 4'd12;
        req    = 6'h04;
        step(1);
        chk("sleep_entry_asleep", {31'h0, asleep}, 32'h1);
        chk("sleep_entry_busy", {31'h0, busy}, 32'h1);
        t = 0;
        while (!(t >= 150 && cyc % 64 == 10)) begin
            if (cyc % 64 == 0) push(8'h10, 3'd1, cyc + 1);
            step(1);
            t++;
        end
        chk("sleep_hold", {31'h0, asleep}, 32'h1);
        n      = cyc;
        energy = 4'd0;
        push(8'h04, 3'd2, n + 2);
        step(1);
        chk("sleep_exit_asleep", {31'h0, asleep}, 32'h0);
        chk("sleep_exit_busy", {31'h0, busy}, 32'h0);
        step(30);
        req = 6'h00;
        step(5);

        chk("queue_empty", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
